// File: rtl/poly_add_sequencer.sv
// Drives the 5:1 polynomial mux select and accumulates up to five polynomials
// coefficient-wise mod q, with a start/busy/done handshake.
module poly_add_sequencer #(
  parameter int unsigned N         = 256,
  parameter int unsigned COEFF_W   = 12,
  parameter int unsigned Q         = 3329,
  parameter int unsigned MAX_TERMS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           num_terms,
  output logic [2:0]           sel_out,
  input  logic [N*COEFF_W-1:0] mux_data,
  output logic                 busy,
  output logic                 done,
  output logic [N*COEFF_W-1:0] acc_out
);

  localparam int unsigned DW = N * COEFF_W;
  localparam int unsigned SW = COEFF_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      n, n_nxt;
  logic [2:0]      cnt, cnt_nxt;
  logic [2:0]      sel_nxt;
  logic            busy_nxt, done_nxt;
  logic [DW-1:0]   acc_nxt;
  logic [2:0]      n_req_c;

  // Single conditional subtract; valid because both operands are below Q.
  function automatic logic [COEFF_W-1:0] modadd(input logic [COEFF_W-1:0] a,
                                                input logic [COEFF_W-1:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s >= SW'(Q)) s = s - SW'(Q);
    return s[COEFF_W-1:0];
  endfunction

  assign n_req_c = (num_terms > 3'(MAX_TERMS)) ? 3'(MAX_TERMS) : num_terms;

  always_comb begin
    state_nxt = state;
    n_nxt     = n;
    cnt_nxt   = cnt;
    sel_nxt   = sel_out;
    acc_nxt   = acc_out;
    case (state)
      IDLE: begin
        sel_nxt = 3'd0;
        cnt_nxt = 3'd0;
        if (start) begin
          n_nxt     = n_req_c;
          acc_nxt   = '0;
          state_nxt = (n_req_c != 3'd0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        for (int i = 0; i < int'(N); i++) begin
          acc_nxt[i*COEFF_W +: COEFF_W] = modadd(acc_out[i*COEFF_W +: COEFF_W],
                                                 mux_data[i*COEFF_W +: COEFF_W]);
        end
        sel_nxt = sel_out + 3'd1;
        cnt_nxt = cnt + 3'd1;
        if (cnt == n - 3'd1) begin
          state_nxt = DONE;
          sel_nxt   = 3'd0;
        end
      end
      DONE: begin
        sel_nxt   = 3'd0;
        state_nxt = IDLE;
      end
      default: begin
        sel_nxt   = 3'd0;
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt == ACCUM);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      n       <= 3'd0;
      cnt     <= 3'd0;
      sel_out <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      acc_out <= '0;
    end else begin
      state   <= state_nxt;
      n       <= n_nxt;
      cnt     <= cnt_nxt;
      sel_out <= sel_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      acc_out <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_poly_add_sequencer.sv
// Directed bench for poly_add_sequencer: models the 5:1 mux behaviourally and
// checks select sequence, latency, handshake and mod-q sums.
module tb_poly_add_sequencer;

  localparam int unsigned N  = 256;
  localparam int unsigned CW = 12;
  localparam int unsigned DW = N * CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    num_terms;
  logic [2:0]    sel_out;
  logic [DW-1:0] mux_data;
  logic          busy;
  logic          done;
  logic [DW-1:0] acc_out;

  logic [DW-1:0] ins [5];
  int            checks = 0;
  int            errors = 0;
  int            sels [$];
  int            busy_lo;
  int            cyc;

  poly_add_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_terms (num_terms),
    .sel_out   (sel_out),
    .mux_data  (mux_data),
    .busy      (busy),
    .done      (done),
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    mux_data = '0;
    if (sel_out < 3'd5) mux_data = ins[sel_out];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int k, input logic [CW-1:0] v);
    for (int i = 0; i < int'(N); i++) ins[k][i*CW +: CW] = v;
  endtask

  task automatic check_acc(input string tag, input logic [CW-1:0] e0,
                           input logic [CW-1:0] e255, input logic [CW-1:0] eo);
    logic [CW-1:0] e;
    for (int i = 0; i < int'(N); i++) begin
      e = (i == 0) ? e0 : (i == 255) ? e255 : eo;
      chk(tag, 32'(acc_out[i*CW +: CW]), 32'(e));
    end
  endtask

  // Issue one start, optionally re-pulse start mid-run, and wait for done.
  task automatic run(input logic [2:0] nt, input int glitch, output int c);
    @(negedge clk);
    start     = 1'b1;
    num_terms = nt;
    @(posedge clk); #1;
    start   = 1'b0;
    sels    = {};
    busy_lo = 0;
    c       = 1;
    while (!done && c < 20) begin
      sels.push_back(int'(sel_out));
      if (!busy) busy_lo++;
      if (c == glitch) begin
        start     = 1'b1;
        num_terms = 3'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      c++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("sel_at_done", 32'(sel_out), 32'd0);
    @(posedge clk); #1;
    chk("done_pulse_end", 32'(done), 32'd0);
  endtask

  task automatic check_sels(input int n);
    chk("sel_count", 32'(sels.size()), 32'(n));
    for (int i = 0; i < sels.size(); i++) chk("sel_seq", 32'(sels[i]), 32'(i));
    chk("busy_in_accum", 32'(busy_lo), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    num_terms = 3'd0;
    for (int k = 0; k < 5; k++) fill(k, 12'd0);
    #1;
    chk("rst_acc", 32'(acc_out == '0), 32'd1);
    chk("rst_sel", 32'(sel_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // T1: five terms of all ones
    for (int k = 0; k < 5; k++) fill(k, 12'd1);
    run(3'd5, 0, cyc);
    chk("t1_latency", 32'(cyc), 32'd6);
    check_sels(5);
    check_acc("t1_acc", 12'd5, 12'd5, 12'd5);

    // T5a: zero terms clears the accumulator and skips ACCUM
    run(3'd0, 0, cyc);
    chk("t5_latency", 32'(cyc), 32'd1);
    check_sels(0);
    check_acc("t5_acc", 12'd0, 12'd0, 12'd0);

    // T2: 3328 + 3328 wraps to 3327
    fill(0, 12'd3328);
    fill(1, 12'd3328);
    run(3'd2, 0, cyc);
    chk("t2_latency", 32'(cyc), 32'd3);
    check_sels(2);
    check_acc("t2_acc", 12'd3327, 12'd3327, 12'd3327);

    // T3: sum exactly Q reduces to 0
    fill(0, 12'd1664);
    fill(1, 12'd1665);
    run(3'd2, 0, cyc);
    check_acc("t3_acc", 12'd0, 12'd0, 12'd0);

    // T4: lane-specific boundaries
    for (int k = 0; k < 5; k++) fill(k, 12'd0);
    ins[2][0 +: CW]      = 12'd3328;
    ins[0][255*CW +: CW] = 12'd3328;
    ins[1][255*CW +: CW] = 12'd1;
    run(3'd3, 0, cyc);
    chk("t4_latency", 32'(cyc), 32'd4);
    check_acc("t4_acc", 12'd3328, 12'd0, 12'd0);

    // T5b: num_terms=7 clamps to 5
    for (int k = 0; k < 5; k++) fill(k, 12'd1);
    run(3'd7, 0, cyc);
    chk("t5b_latency", 32'(cyc), 32'd6);
    check_sels(5);
    check_acc("t5b_acc", 12'd5, 12'd5, 12'd5);

    // T6a: start re-pulsed (with new num_terms) mid-run is ignored
    for (int k = 0; k < 5; k++) fill(k, 12'd2);
    run(3'd5, 2, cyc);
    chk("t6_latency", 32'(cyc), 32'd6);
    check_sels(5);
    check_acc("t6_acc", 12'd10, 12'd10, 12'd10);

    // T6b: reset in the third ACCUM cycle aborts without done
    for (int k = 0; k < 5; k++) fill(k, 12'd1);
    @(negedge clk);
    start     = 1'b1;
    num_terms = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t6b_busy_c1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6b_sel_c3", 32'(sel_out), 32'd2);
    rst = 1'b1;
    #1;
    chk("t6b_rst_acc", 32'(acc_out == '0), 32'd1);
    chk("t6b_rst_sel", 32'(sel_out), 32'd0);
    chk("t6b_rst_busy", 32'(busy), 32'd0);
    chk("t6b_rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t6b_no_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t6b_idle_no_done", 32'(done), 32'd0);
    end
    run(3'd5, 0, cyc);
    chk("t6b_latency", 32'(cyc), 32'd6);
    check_acc("t6b_acc", 12'd5, 12'd5, 12'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
